// File: rtl/dmem_if.sv
// Bundle of the two requester ports and the single-port data memory port.
// The arbiter uses the slave view; the environment (CPU, debug, memory) uses master.
interface dmem_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW     = 15
) ();
  logic                  c_req;
  logic                  c_we;
  logic [ADDR_WIDTH-1:0] c_addr;
  logic [DATA_WIDTH-1:0] c_wdata;
  logic [3:0]            c_wmask;
  logic                  c_gnt;
  logic                  c_rvalid;
  logic [DATA_WIDTH-1:0] c_rdata;

  logic                  d_req;
  logic                  d_we;
  logic [ADDR_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0] d_wdata;
  logic [3:0]            d_wmask;
  logic                  d_gnt;
  logic                  d_rvalid;
  logic [DATA_WIDTH-1:0] d_rdata;

  logic [MEM_AW-1:0]     m_addr;
  logic [DATA_WIDTH-1:0] m_wdata;
  logic [3:0]            m_wmask;
  logic                  m_we;
  logic [DATA_WIDTH-1:0] m_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata, c_wmask,
    output c_gnt, c_rvalid, c_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wmask,
    output d_gnt, d_rvalid, d_rdata,
    output m_addr, m_wdata, m_wmask, m_we,
    input  m_rdata
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata, c_wmask,
    input  c_gnt, c_rvalid, c_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wmask,
    input  d_gnt, d_rvalid, d_rdata,
    input  m_addr, m_wdata, m_wmask, m_we,
    output m_rdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for a single-port data memory: CPU has fixed priority,
// debug port is forced through after STARVE_LIMIT denied cycles; reads tracked by owner.
module dmem_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int MEM_AW       = 15,
  parameter int RD_LATENCY   = 1,
  parameter int STARVE_LIMIT = 4
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0]      starve_cnt_reg, starve_cnt_next;
  logic                  c_win, d_win, any_win, win_we, rd_issue;
  logic [MEM_AW-1:0]     win_addr, addr_reg;
  logic [DATA_WIDTH-1:0] win_wdata, wdata_reg;
  logic [3:0]            win_wmask, wmask_reg;
  logic                  rd_valid, rd_owner;

  always_comb begin
    d_win     = !rst && bus.d_req &&
                (!bus.c_req || starve_cnt_reg == CNT_W'(STARVE_LIMIT));
    c_win     = !rst && bus.c_req && !d_win;
    any_win   = c_win || d_win;
    win_we    = d_win ? bus.d_we : bus.c_we;
    win_addr  = d_win ? bus.d_addr[MEM_AW-1:0] : bus.c_addr[MEM_AW-1:0];
    win_wdata = d_win ? bus.d_wdata : bus.c_wdata;
    win_wmask = d_win ? bus.d_wmask : bus.c_wmask;
    rd_issue  = any_win && !win_we;
  end

  // Counts consecutive denied debug cycles; any grant or idle debug cycle clears it.
  always_comb begin
    starve_cnt_next = '0;
    if (bus.d_req && !d_win) begin
      if (starve_cnt_reg == CNT_W'(STARVE_LIMIT))
        starve_cnt_next = starve_cnt_reg;
      else
        starve_cnt_next = starve_cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_reg <= '0;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      wmask_reg      <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
      if (any_win) begin
        addr_reg  <= win_addr;
        wdata_reg <= win_wdata;
        wmask_reg <= win_wmask;
      end
    end
  end

  // Memory side mirrors the winner; idle cycles replay the last access fields.
  assign bus.c_gnt   = c_win;
  assign bus.d_gnt   = d_win;
  assign bus.m_we    = any_win && win_we;
  assign bus.m_addr  = rst ? '0 : (any_win ? win_addr  : addr_reg);
  assign bus.m_wdata = rst ? '0 : (any_win ? win_wdata : wdata_reg);
  assign bus.m_wmask = rst ? '0 : (any_win ? win_wmask : wmask_reg);

  genvar gi;
  generate
    if (RD_LATENCY == 0) begin : g_comb
      assign rd_valid = rd_issue;
      assign rd_owner = d_win;
    end else begin : g_pipe
      logic valid_reg [RD_LATENCY];
      logic owner_reg [RD_LATENCY];

      always_ff @(posedge clk) begin
        if (rst) begin
          valid_reg[0] <= 1'b0;
          owner_reg[0] <= 1'b0;
        end else begin
          valid_reg[0] <= rd_issue;
          owner_reg[0] <= d_win;
        end
      end

      for (gi = 1; gi < RD_LATENCY; gi++) begin : g_stage
        always_ff @(posedge clk) begin
          if (rst) begin
            valid_reg[gi] <= 1'b0;
            owner_reg[gi] <= 1'b0;
          end else begin
            valid_reg[gi] <= valid_reg[gi-1];
            owner_reg[gi] <= owner_reg[gi-1];
          end
        end
      end

      // Gate with rst so a response due in the first reset cycle is dropped too.
      assign rd_valid = valid_reg[RD_LATENCY-1] && !rst;
      assign rd_owner = owner_reg[RD_LATENCY-1];
    end
  endgenerate

  assign bus.c_rvalid = rd_valid && !rd_owner;
  assign bus.d_rvalid = rd_valid && rd_owner;
  assign bus.c_rdata  = bus.c_rvalid ? bus.m_rdata : '0;
  assign bus.d_rdata  = bus.d_rvalid ? bus.m_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Drives one request stream into four arbiters (read latency 0..3), each with its own
// memory, and checks every cycle against a transaction-level model of the arbitration rules.
module tb_dmem_arbiter;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int MAW  = 15;
  localparam int SL   = 4;
  localparam int NI   = 4;
  localparam int MAXC = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          c_req, c_we, d_req, d_we;
  logic [31:0]   c_addr, c_wdata, d_addr, d_wdata;
  logic [3:0]    c_wmask, d_wmask;

  logic          obs_cg [NI], obs_dg [NI], obs_cv [NI], obs_dv [NI], obs_mwe [NI];
  logic [31:0]   obs_cd [NI], obs_dd [NI], obs_mwd [NI];
  logic [14:0]   obs_ma [NI];
  logic [3:0]    obs_mwm [NI];

  function automatic logic [31:0] init_word(int i);
    if (i == 4) return 32'hDEADBEEF;
    if (i == 8) return 32'hAAAAAAAA;
    return 32'h5A00_0000 ^ (i * 32'h0001_0203);
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < NI; gi++) begin : g_inst
      dmem_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW)) bus ();
      logic [31:0] mem [256];
      logic [31:0] rpipe [4];

      assign bus.c_req = c_req;   assign bus.c_we = c_we;     assign bus.c_addr = c_addr;
      assign bus.c_wdata = c_wdata; assign bus.c_wmask = c_wmask;
      assign bus.d_req = d_req;   assign bus.d_we = d_we;     assign bus.d_addr = d_addr;
      assign bus.d_wdata = d_wdata; assign bus.d_wmask = d_wmask;
      assign bus.m_rdata = (gi == 0) ? mem[bus.m_addr[9:2]] : rpipe[(gi == 0) ? 0 : gi - 1];

      dmem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_AW(MAW),
                     .RD_LATENCY(gi), .STARVE_LIMIT(SL)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
      );

      initial for (int i = 0; i < 256; i++) mem[i] = init_word(i);

      // Environment memory: writes land at the edge, reads sampled before that write.
      always @(posedge clk) begin
        if (bus.m_we)
          for (int b = 0; b < 4; b++)
            if (bus.m_wmask[b]) mem[bus.m_addr[9:2]][8*b +: 8] <= bus.m_wdata[8*b +: 8];
        rpipe[0] <= mem[bus.m_addr[9:2]];
        for (int k = 1; k < 4; k++) rpipe[k] <= rpipe[k-1];
      end

      assign obs_cg[gi] = bus.c_gnt;    assign obs_dg[gi] = bus.d_gnt;
      assign obs_cv[gi] = bus.c_rvalid; assign obs_dv[gi] = bus.d_rvalid;
      assign obs_cd[gi] = bus.c_rdata;  assign obs_dd[gi] = bus.d_rdata;
      assign obs_mwe[gi] = bus.m_we;    assign obs_ma[gi] = bus.m_addr;
      assign obs_mwd[gi] = bus.m_wdata; assign obs_mwm[gi] = bus.m_wmask;
    end
  endgenerate

  // Reference model state
  int          n_cmp = 0, n_bad = 0, cyc = 0, starve = 0;
  int          n_dg_obs = 0, n_we_obs = 0;
  logic [31:0] ref_mem [256];
  logic        iss_v [MAXC], iss_own [MAXC], rst_hist [MAXC];
  logic [31:0] iss_dat [MAXC];
  logic [14:0] last_addr = '0;
  logic [31:0] last_wdata = '0;
  logic [3:0]  last_wmask = '0;
  logic        g_c = 1'b0, g_d = 1'b0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic set_c(logic req, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] wm);
    c_req = req; c_we = we; c_addr = a; c_wdata = wd; c_wmask = wm;
  endtask

  task automatic set_d(logic req, logic we, logic [31:0] a, logic [31:0] wd, logic [3:0] wm);
    d_req = req; d_we = we; d_addr = a; d_wdata = wd; d_wmask = wm;
  endtask

  task automatic rand_req(output logic we, output logic [31:0] a, output logic [31:0] wd,
                          output logic [3:0] wm);
    logic [31:0] r;
    logic [7:0]  idx;
    r   = $urandom();
    idx = 8'($urandom_range(0, 15));
    we  = ($urandom_range(0, 2) == 0);
    a   = {r[31:15], 5'b0, idx, 2'b00};
    wd  = $urandom();
    wm  = 4'($urandom_range(0, 15));
  endtask

  // One clock cycle: compare all instances at the negedge, then advance the model.
  task automatic step();
    logic        ew_c, ew_d, ew, we, ok, own;
    logic [31:0] a, wd, ed;
    logic [3:0]  wm;
    logic [14:0] e_ma;
    logic [31:0] e_mwd;
    logic [3:0]  e_mwm;
    int          t;
    @(negedge clk);
    ew_d = !rst && d_req && (starve == SL || !c_req);
    ew_c = !rst && c_req && !ew_d;
    ew   = ew_c || ew_d;
    we   = ew_d ? d_we : c_we;
    a    = ew_d ? d_addr : c_addr;
    wd   = ew_d ? d_wdata : c_wdata;
    wm   = ew_d ? d_wmask : c_wmask;
    rst_hist[cyc] = rst;
    iss_v[cyc]    = ew && !we;
    iss_own[cyc]  = ew_d;
    iss_dat[cyc]  = ref_mem[a[9:2]];
    e_ma  = rst ? 15'h0 : (ew ? a[14:0] : last_addr);
    e_mwd = rst ? 32'h0 : (ew ? wd : last_wdata);
    e_mwm = rst ? 4'h0 : (ew ? wm : last_wmask);
    for (int i = 0; i < NI; i++) begin
      t  = cyc - i;
      ok = (t >= 0) && iss_v[t >= 0 ? t : 0];
      for (int k = t + 1; k <= cyc; k++) if (ok && rst_hist[k]) ok = 1'b0;
      own = ok && iss_own[t];
      ed  = ok ? iss_dat[t] : 32'h0;
      chk($sformatf("c_gnt[L%0d]", i), 64'(obs_cg[i]), 64'(ew_c));
      chk($sformatf("d_gnt[L%0d]", i), 64'(obs_dg[i]), 64'(ew_d));
      chk($sformatf("m_we[L%0d]", i), 64'(obs_mwe[i]), 64'(ew && we));
      chk($sformatf("m_addr[L%0d]", i), 64'(obs_ma[i]), 64'(e_ma));
      chk($sformatf("m_wdata_mask[L%0d]", i), {28'h0, obs_mwm[i], obs_mwd[i]},
          {28'h0, e_mwm, e_mwd});
      chk($sformatf("c_rvalid[L%0d]", i), 64'(obs_cv[i]), 64'(ok && !own));
      chk($sformatf("d_rvalid[L%0d]", i), 64'(obs_dv[i]), 64'(own));
      chk($sformatf("c_rdata[L%0d]", i), 64'(obs_cd[i]), 64'((ok && !own) ? ed : 32'h0));
      chk($sformatf("d_rdata[L%0d]", i), 64'(obs_dd[i]), 64'(own ? ed : 32'h0));
    end
    n_dg_obs += int'(obs_dg[2]);
    n_we_obs += int'(obs_mwe[2]);
    $display("cyc=%0d rst=%0b c_req=%0b d_req=%0b gnt=%0b%0b we=%0b addr=%h rv(L1)=%0b%0b",
             cyc, rst, c_req, d_req, ew_c, ew_d, ew && we, a[14:0], obs_cv[1], obs_dv[1]);
    if (ew && we)
      for (int b = 0; b < 4; b++) if (wm[b]) ref_mem[a[9:2]][8*b +: 8] = wd[8*b +: 8];
    if (rst) begin
      last_addr = '0; last_wdata = '0; last_wmask = '0;
    end else if (ew) begin
      last_addr = a[14:0]; last_wdata = wd; last_wmask = wm;
    end
    if (rst || !d_req || ew_d) starve = 0;
    else if (starve < SL) starve++;
    g_c = ew_c;
    g_d = ew_d;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  initial begin
    int          base;
    logic        we;
    logic [31:0] a, wd;
    logic [3:0]  wm;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    rst = 1'b1;
    set_c(0, 0, 0, 0, 0);
    set_d(0, 0, 0, 0, 0);
    step(); step();
    rst = 1'b0;
    step();

    // CPU-only read of 0xDEADBEEF
    set_c(1, 0, 32'h10, 0, 0); step();
    set_c(0, 0, 0, 0, 0); step(); step(); step(); step();

    // Continuous contention: debug must win every fifth cycle
    base = n_dg_obs;
    set_c(1, 0, 32'h40, 0, 0);
    set_d(1, 0, 32'h44, 0, 0);
    for (int n = 0; n < 10; n++) step();
    chk("contention_d_gnt_count", 64'(n_dg_obs - base), 64'd2);
    set_c(0, 0, 0, 0, 0); set_d(0, 0, 0, 0, 0);
    step(); step(); step(); step();

    // Debug partial write then CPU read of the merged word
    base = n_we_obs;
    set_d(1, 1, 32'h20, 32'h12345678, 4'b0011); step();
    set_d(0, 0, 0, 0, 0); set_c(1, 0, 32'h20, 0, 0); step();
    set_c(0, 0, 0, 0, 0); step(); step(); step(); step();
    chk("partial_write_we_pulses", 64'(n_we_obs - base), 64'd1);

    // Interleaved reads C, D, C on consecutive cycles
    set_c(1, 0, 32'h0, 0, 0); step();
    set_c(0, 0, 0, 0, 0); set_d(1, 0, 32'h4, 0, 0); step();
    set_d(0, 0, 0, 0, 0); set_c(1, 0, 32'h8, 0, 0); step();
    set_c(0, 0, 0, 0, 0); step(); step(); step(); step();

    // Reset one cycle after a read grant, with a request pending through reset
    set_c(1, 0, 32'h10, 0, 0); step();
    set_c(1, 0, 32'h14, 0, 0); rst = 1'b1; step(); step();
    rst = 1'b0; step();
    set_c(0, 0, 0, 0, 0); step(); step(); step(); step();

    // Randomized traffic with occasional reset
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 99) == 0);
      if (!c_req || g_c) begin
        if ($urandom_range(0, 9) < 6) begin
          rand_req(we, a, wd, wm); set_c(1, we, a, wd, wm);
        end else set_c(0, 0, 0, 0, 0);
      end
      if (!d_req || g_d) begin
        if ($urandom_range(0, 9) < 5) begin
          rand_req(we, a, wd, wm); set_d(1, we, a, wd, wm);
        end else set_d(0, 0, 0, 0, 0);
      end
      step();
    end
    rst = 1'b0;
    set_c(0, 0, 0, 0, 0); set_d(0, 0, 0, 0, 0);
    for (int n = 0; n < 6; n++) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
